// File: rtl/router_sw_alloc.sv
// router_sw_alloc: five-port round-robin switch allocator with registered crossbar selects, queue pops and a saturating drop counter
module router_sw_alloc #(
  parameter int NPORT = 5
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [NPORT-1:0]       q_valid_i,
  input  logic [NPORT*NPORT-1:0] req_i,
  input  logic [NPORT-1:0]       out_ready_i,
  output logic [NPORT*NPORT-1:0] grant_o,
  output logic [NPORT-1:0]       out_valid_o,
  output logic [NPORT-1:0]       q_pop_o,
  output logic [7:0]             drop_cnt_o
);
  logic [2:0] ptr [NPORT];
  logic [2:0] ptr_nxt [NPORT];
  logic [NPORT*NPORT-1:0] grant_nxt;
  logic [NPORT-1:0] elig, fwd, drop, pop_nxt;
  logic [8:0] drop_sum;
  // a head popped last cycle is stale until the queue advances
  always_comb begin
    for (int i = 0; i < NPORT; i++) begin
      elig[i] = q_valid_i[i] && !q_pop_o[i];
      fwd[i] = elig[i] && $onehot(req_i[NPORT*i +: NPORT]);
      drop[i] = elig[i] && !$onehot(req_i[NPORT*i +: NPORT]);
    end
  end
  always_comb begin
    int idx;
    int w;
    grant_nxt = '0;
    pop_nxt = drop;
    for (int o = 0; o < NPORT; o++) begin
      ptr_nxt[o] = ptr[o];
      w = -1;
      for (int k = 0; k < NPORT; k++) begin
        idx = (int'(ptr[o]) + k) % NPORT;
        if (w < 0 && fwd[idx] && req_i[NPORT*idx + o]) w = idx;
      end
      if (out_ready_i[o] && w >= 0) begin
        grant_nxt[NPORT*o + w] = 1'b1;
        pop_nxt[w] = 1'b1;
        ptr_nxt[o] = 3'((w + 1) % NPORT);
      end
    end
    drop_sum = {1'b0, drop_cnt_o} + 9'($countones(drop));
  end
  always_comb begin
    for (int o = 0; o < NPORT; o++) out_valid_o[o] = |grant_o[NPORT*o +: NPORT];
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      grant_o <= '0;
      q_pop_o <= '0;
      drop_cnt_o <= '0;
      for (int o = 0; o < NPORT; o++) ptr[o] <= '0;
    end else begin
      grant_o <= grant_nxt;
      q_pop_o <= pop_nxt;
      drop_cnt_o <= drop_sum[8] ? 8'hff : drop_sum[7:0];
      for (int o = 0; o < NPORT; o++) ptr[o] <= ptr_nxt[o];
    end
  end
endmodule

// File: tb/tb_router_sw_alloc.sv
// tb_router_sw_alloc: directed vector table plus hand sequences for stall, saturation and async reset
module tb_router_sw_alloc;
  localparam logic [4:0] RN = 5'b00001, RS = 5'b00010, RE = 5'b00100, RW = 5'b01000, RL = 5'b10000;
  localparam logic [4:0] RDY = 5'b11111, NW = 5'b10111;
  typedef struct {
    logic [4:0]  qv;
    logic [24:0] req;
    logic [4:0]  rdy;
    logic [24:0] g;
    logic [4:0]  pop;
    logic [4:0]  vld;
    logic [7:0]  drp;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] q_valid = '0;
  logic [24:0] req = '0;
  logic [4:0] out_ready = '0;
  logic [24:0] grant;
  logic [4:0] out_valid, q_pop;
  logic [7:0] drop_cnt;
  int total = 0;
  int bad = 0;
  vec_t vecs[$];
  router_sw_alloc dut (
    .clk_i(clk), .rst_n_i(rst_n), .q_valid_i(q_valid), .req_i(req),
    .out_ready_i(out_ready), .grant_o(grant), .out_valid_o(out_valid),
    .q_pop_o(q_pop), .drop_cnt_o(drop_cnt)
  );
  always #5 clk = ~clk;
  function automatic logic [24:0] mk(input logic [4:0] a0, a1, a2, a3, a4);
    return {a4, a3, a2, a1, a0};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic add(input logic [4:0] qv, input logic [24:0] r, input logic [4:0] rdy,
                     input logic [24:0] g, input logic [4:0] pop, input logic [4:0] vld, input logic [7:0] drp);
    vec_t v;
    v.qv = qv; v.req = r; v.rdy = rdy; v.g = g; v.pop = pop; v.vld = vld; v.drp = drp;
    vecs.push_back(v);
  endtask
  task automatic drive(input logic [4:0] qv, input logic [24:0] r, input logic [4:0] rdy);
    q_valid = qv; req = r; out_ready = rdy;
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [24:0] rr, bp, par, par_g;
    rr = mk(RE, RE, 0, RE, 0);
    bp = mk(0, 0, RW, 0, RW);
    par = mk(RL, RE, RW, RN, RS);
    par_g = mk(5'b01000, 5'b10000, 5'b00010, 5'b00100, 5'b00001);
    add(5'b00001, mk(RL, 0, 0, 0, 0), RDY, mk(0, 0, 0, 0, 5'b00001), 5'b00001, 5'b10000, 8'd0);
    add(5'b00001, mk(RL, 0, 0, 0, 0), RDY, '0, '0, '0, 8'd0);
    add(5'b01011, rr, RDY, mk(0, 0, 5'b00001, 0, 0), 5'b00001, 5'b00100, 8'd0);
    add(5'b01011, rr, RDY, mk(0, 0, 5'b00010, 0, 0), 5'b00010, 5'b00100, 8'd0);
    add(5'b01011, rr, RDY, mk(0, 0, 5'b01000, 0, 0), 5'b01000, 5'b00100, 8'd0);
    add(5'b01011, rr, RDY, mk(0, 0, 5'b00001, 0, 0), 5'b00001, 5'b00100, 8'd0);
    add(5'b01011, rr, RDY, mk(0, 0, 5'b00010, 0, 0), 5'b00010, 5'b00100, 8'd0);
    add(5'b01011, rr, RDY, mk(0, 0, 5'b01000, 0, 0), 5'b01000, 5'b00100, 8'd0);
    add(5'b00000, '0, RDY, '0, '0, '0, 8'd0);
    add(5'b10100, bp, RDY, mk(0, 0, 0, 5'b00100, 0), 5'b00100, 5'b01000, 8'd0);
    add(5'b10100, bp, NW, '0, '0, '0, 8'd0);
    add(5'b10100, bp, NW, '0, '0, '0, 8'd0);
    add(5'b10100, bp, RDY, mk(0, 0, 0, 5'b10000, 0), 5'b10000, 5'b01000, 8'd0);
    add(5'b00000, '0, RDY, '0, '0, '0, 8'd0);
    add(5'b00110, mk(0, 5'b00000, 5'b00011, 0, 0), RDY, '0, 5'b00110, '0, 8'd2);
    add(5'b00000, '0, RDY, '0, '0, '0, 8'd2);
    add(5'b11111, par, RDY, par_g, 5'b11111, 5'b11111, 8'd2);
    add(5'b11111, par, RDY, '0, '0, '0, 8'd2);
    add(5'b00000, '0, RDY, '0, '0, '0, 8'd2);
    #1;
    chk("reset_grant", 32'(grant), 0);
    chk("reset_pop", 32'(q_pop), 0);
    chk("reset_drop", 32'(drop_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    foreach (vecs[n]) begin
      drive(vecs[n].qv, vecs[n].req, vecs[n].rdy);
      chk($sformatf("v%0d_grant", n), 32'(grant), 32'(vecs[n].g));
      chk($sformatf("v%0d_pop", n), 32'(q_pop), 32'(vecs[n].pop));
      chk($sformatf("v%0d_valid", n), 32'(out_valid), 32'(vecs[n].vld));
      chk($sformatf("v%0d_drop", n), 32'(drop_cnt), 32'(vecs[n].drp));
    end
    for (int c = 0; c < 10; c++) begin
      drive(5'b10100, bp, NW);
      chk($sformatf("stall%0d_grant", c), 32'(grant), 0);
      chk($sformatf("stall%0d_pop", c), 32'(q_pop), 0);
    end
    drive(5'b10100, bp, RDY);
    chk("stall_release_grant", 32'(grant), 32'(mk(0, 0, 0, 5'b10000, 0)));
    chk("stall_release_pop", 32'(q_pop), 32'(5'b10000));
    drive(5'b00000, '0, RDY);
    drive(5'b11111, '0, RDY);
    chk("sat_first_drop", 32'(drop_cnt), 7);
    chk("sat_first_pop", 32'(q_pop), 32'(5'b11111));
    drive(5'b11111, '0, RDY);
    chk("sat_masked_drop", 32'(drop_cnt), 7);
    for (int c = 0; c < 150; c++) drive(5'b11111, '0, RDY);
    chk("sat_drop", 32'(drop_cnt), 255);
    drive(5'b00000, '0, RDY);
    chk("sat_hold", 32'(drop_cnt), 255);
    drive(5'b11111, par, RDY);
    chk("pre_reset_grant", 32'(grant), 32'(par_g));
    chk("pre_reset_drop", 32'(drop_cnt), 255);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_grant", 32'(grant), 0);
    chk("async_pop", 32'(q_pop), 0);
    chk("async_valid", 32'(out_valid), 0);
    chk("async_drop", 32'(drop_cnt), 0);
    q_valid = 5'b01011; req = rr; out_ready = RDY;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_grant", 32'(grant), 32'(mk(0, 0, 5'b00001, 0, 0)));
    chk("post_reset_pop", 32'(q_pop), 32'(5'b00001));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
